// File: rtl/color_centroid_tracker.sv
// Per-channel colour-class centroid tracker: qualifies pixels, accumulates weighted x/y sums per frame.
// Divides the sums out with one shared restoring divider: ACC_W+2 cycles per job, or 2 for an empty channel.
// No backpressure: a frame boundary that arrives while busy is dropped and sets the sticky overrun flag.
module color_centroid_tracker #(
  parameter int NUM_CH = 2,
  parameter int X_W    = 11,
  parameter int Y_W    = 10,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 23,
  parameter int X_OFF  = 152,
  parameter int Y_OFF  = 144,
  parameter int X_DEF  = 512,
  parameter int Y_DEF  = 384
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  input  logic                  sof,
  input  logic [17:0]           pixel,
  input  logic [X_W-1:0]        x,
  input  logic [Y_W-1:0]        y,
  input  logic [2*NUM_CH-1:0]   ch_sel,
  input  logic [5*NUM_CH-1:0]   ch_min,
  input  logic [5*NUM_CH-1:0]   ch_diff,
  output logic [NUM_CH-1:0]     included,
  output logic [10*NUM_CH-1:0]  x_center,
  output logic [10*NUM_CH-1:0]  y_center,
  output logic [NUM_CH-1:0]     found,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NJOB = 2 * NUM_CH;
  localparam int JW   = (NJOB > 1) ? $clog2(NJOB) : 1;
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW   = $clog2(ACC_W + 1);
  localparam int XP_W = X_W + 3;
  localparam int YP_W = Y_W + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Only the top 5 bits of each 6-bit colour take part in qualification.
  logic [4:0] col_r, col_g, col_b;
  logic       unused_pixel_lsbs;
  assign col_r = pixel[17:13];
  assign col_g = pixel[11:7];
  assign col_b = pixel[5:1];
  assign unused_pixel_lsbs = ^{pixel[12], pixel[6], pixel[0]};

  // Main colour must beat the floor and clear both other colours by more than the margin.
  // The margin is only meaningful when other < main, so the subtraction never wraps in a
  // term that can make the result true.
  function automatic logic qualify(input logic [1:0] sel, input logic [4:0] r,
                                   input logic [4:0] g, input logic [4:0] b,
                                   input logic [4:0] cmin, input logic [4:0] cdiff);
    logic [4:0] mn, oa, ob;
    mn = r;
    oa = g;
    ob = b;
    case (sel)
      2'd1: begin mn = g; oa = r; ob = b; end
      2'd2: begin mn = b; oa = r; ob = g; end
      default: ;
    endcase
    return (sel != 2'd3) && (mn > cmin) && (oa < mn) && (ob < mn) &&
           ((mn - oa) > cdiff) && ((mn - ob) > cdiff);
  endfunction

  function automatic logic [ACC_W-1:0] sat_add_acc(input logic [ACC_W-1:0] a,
                                                   input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_add_cnt(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [1:0]       hist     [NUM_CH];
  logic [1:0]       hist_eff [NUM_CH];
  logic [2:0]       wgt      [NUM_CH];
  logic [XP_W-1:0]  x_add    [NUM_CH];
  logic [YP_W-1:0]  y_add    [NUM_CH];
  logic [ACC_W-1:0] xsum     [NUM_CH];
  logic [ACC_W-1:0] ysum     [NUM_CH];
  logic [CNT_W-1:0] cnt      [NUM_CH];
  logic [ACC_W-1:0] xsum_sat [NUM_CH];
  logic [ACC_W-1:0] ysum_sat [NUM_CH];
  logic [CNT_W-1:0] cnt_sat  [NUM_CH];

  // Per-channel qualification, run-length weight and saturating next sums
  always_comb begin
    included = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      included[c] = pix_valid && qualify(ch_sel[2*c +: 2], col_r, col_g, col_b,
                                         ch_min[5*c +: 5], ch_diff[5*c +: 5]);
      // Column 0 starts a fresh line, so history from the previous line is ignored.
      hist_eff[c] = (x == '0) ? 2'b00 : hist[c];
      if (!included[c])              wgt[c] = 3'd0;
      else if (hist_eff[c] == 2'b11) wgt[c] = 3'd4;
      else if (hist_eff[c] == 2'b00) wgt[c] = 3'd1;
      else                           wgt[c] = 3'd2;
      x_add[c]    = XP_W'(wgt[c]) * XP_W'(x);
      y_add[c]    = YP_W'(wgt[c]) * YP_W'(y);
      xsum_sat[c] = sat_add_acc(xsum[c], ACC_W'(x_add[c]));
      ysum_sat[c] = sat_add_acc(ysum[c], ACC_W'(y_add[c]));
      cnt_sat[c]  = sat_add_cnt(cnt[c], CNT_W'(wgt[c]));
    end
  end

  logic frame_end;
  assign frame_end = pix_valid && sof;

  // Accumulate each qualified pixel; a frame-start pixel restarts the sums with its own share
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        hist[c] <= '0;
        xsum[c] <= '0;
        ysum[c] <= '0;
        cnt[c]  <= '0;
      end
    end else if (pix_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        hist[c] <= {hist_eff[c][0], included[c]};
        if (sof) begin
          xsum[c] <= ACC_W'(x_add[c]);
          ysum[c] <= ACC_W'(y_add[c]);
          cnt[c]  <= CNT_W'(wgt[c]);
        end else begin
          xsum[c] <= xsum_sat[c];
          ysum[c] <= ysum_sat[c];
          cnt[c]  <= cnt_sat[c];
        end
      end
    end
  end

  logic [ACC_W-1:0] snap_x [NUM_CH];
  logic [ACC_W-1:0] snap_y [NUM_CH];
  logic [CNT_W-1:0] snap_c [NUM_CH];

  // Hand the finished frame to the divider when free; otherwise drop it and flag the loss
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        snap_x[c] <= '0;
        snap_y[c] <= '0;
        snap_c[c] <= '0;
      end
    end else if (frame_end) begin
      if (state == S_IDLE) begin
        for (int c = 0; c < NUM_CH; c++) begin
          snap_x[c] <= xsum[c];
          snap_y[c] <= ysum[c];
          snap_c[c] <= cnt[c];
        end
      end else begin
        overrun <= 1'b1;
      end
    end
  end

  logic [JW-1:0]    job;
  logic [CW-1:0]    job_ch;
  logic [IW-1:0]    iter;
  logic [ACC_W-1:0] quo;
  logic [CNT_W-1:0] dvsr;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_sub;
  logic [CNT_W:0]   trial;
  logic             take;
  logic [9:0]       x_stg [NUM_CH];
  logic [9:0]       y_stg [NUM_CH];
  logic [NUM_CH-1:0] found_stg;

  // Jobs run ch0x, ch0y, ch1x, ...; the channel is the job index without its x/y bit.
  assign job_ch = CW'(job >> 1);
  // Restoring step: bring down the next dividend bit and subtract when the divisor fits.
  // When it fits the difference is below the divisor, so the low bits hold it exactly.
  assign trial   = {rem, quo[ACC_W-1]};
  assign take    = (trial >= {1'b0, dvsr});
  assign rem_sub = trial[CNT_W-1:0] - dvsr;

  // Divider state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Divider next-state: empty channels skip straight from LOAD to NEXT
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (frame_end) state_nxt = S_LOAD;
      S_LOAD: state_nxt = (snap_c[job_ch] == '0) ? S_NEXT : S_DIV;
      S_DIV:  if (iter == IW'(ACC_W - 1)) state_nxt = S_NEXT;
      S_NEXT: state_nxt = (job == JW'(NJOB - 1)) ? S_DONE : S_LOAD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Divider datapath: operand load, one quotient bit per cycle, result staging
  always_ff @(posedge clk) begin
    if (reset) begin
      job       <= '0;
      iter      <= '0;
      quo       <= '0;
      dvsr      <= '0;
      rem       <= '0;
      found_stg <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        x_stg[c] <= 10'(X_DEF);
        y_stg[c] <= 10'(Y_DEF);
      end
    end else begin
      case (state)
        S_LOAD: begin
          dvsr <= snap_c[job_ch];
          quo  <= job[0] ? snap_y[job_ch] : snap_x[job_ch];
          rem  <= '0;
          iter <= '0;
        end
        S_DIV: begin
          rem  <= take ? rem_sub : trial[CNT_W-1:0];
          quo  <= {quo[ACC_W-2:0], take};
          iter <= iter + IW'(1);
        end
        S_NEXT: begin
          if (!job[0]) begin
            x_stg[job_ch]     <= (dvsr == '0) ? 10'(X_DEF) : quo[9:0] + 10'(X_OFF);
            found_stg[job_ch] <= (dvsr != '0);
          end else begin
            y_stg[job_ch]     <= (dvsr == '0) ? 10'(Y_DEF) : quo[9:0] + 10'(Y_OFF);
          end
          job <= (job == JW'(NJOB - 1)) ? '0 : job + JW'(1);
        end
        default: ;
      endcase
    end
  end

  // Publish every staged result together, with a one-cycle pulse as DONE retires
  always_ff @(posedge clk) begin
    if (reset) begin
      x_center     <= {NUM_CH{10'(X_DEF)}};
      y_center     <= {NUM_CH{10'(Y_DEF)}};
      found        <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        for (int c = 0; c < NUM_CH; c++) begin
          x_center[10*c +: 10] <= x_stg[c];
          y_center[10*c +: 10] <= y_stg[c];
        end
        found <= found_stg;
      end
    end
  end

endmodule

// File: doc/color_centroid_tracker.md
Name: color_centroid_tracker

Overview:
- Multi-channel successor to the single-colour centre-of-mass block.
- Tracks the weighted centroid of NUM_CH independently configured colour classes over each video frame.
- Uses an in-block sequential restoring divider (no divider IP) and a frame-result valid pulse.
- Sits between the pixel pipeline and the tracking/overlay logic; one result set is produced per frame.

Parameters:
- NUM_CH, 2, number of independent colour channels.
- X_W, 11, pixel x coordinate width.
- Y_W, 10, pixel y coordinate width.
- ACC_W, 32, per-channel x/y weighted-sum accumulator width.
- CNT_W, 23, per-channel weight-count accumulator width.
- X_OFF, 152, constant added to x quotient.
- Y_OFF, 144, constant added to y quotient.
- X_DEF, 512, x output when channel count is zero.
- Y_DEF, 384, y output when channel count is zero.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pix_valid  in  1  pixel/x/y qualify this cycle
- sof  in  1  first pixel of frame (qualified by pix_valid)
- pixel  in  18  {R[17:12],G[11:6],B[5:0]}; top 5 bits of each colour used
- x  in  X_W  pixel column
- y  in  Y_W  pixel row
- ch_sel  in  2*NUM_CH  per-channel main colour: 0=R, 1=G, 2=B; 3 means channel disabled
- ch_min  in  5*NUM_CH  per-channel minimum main-colour value
- ch_diff  in  5*NUM_CH  per-channel minimum margin over both other colours
- included  out  NUM_CH  combinational per-channel pixel qualification
- x_center  out  10*NUM_CH  registered per-channel x result
- y_center  out  10*NUM_CH  registered per-channel y result
- found  out  NUM_CH  channel had nonzero count in the last completed frame
- result_valid  out  1  one-cycle pulse when all channel results are updated
- busy  out  1  divider FSM not IDLE
- overrun  out  1  sticky flag; set when sof arrives while busy; cleared only by reset

Behaviour:
- Qualification (per channel c):
  - included[c] requires all of: pix_valid; ch_sel≠3; main>ch_min; each other colour<main; (main−other)>ch_diff for both other colours.
  - Colour values are 5-bit unsigned; subtraction is performed only when other<main, so there is no underflow.
- Weighting:
  - Per-channel 2-bit history of included, shifted on each pix_valid.
  - History is cleared on a pix_valid cycle with x==0, so it never wraps across lines.
  - Weight is 4 if both history bits are 1, 1 if both are 0, otherwise 2.
  - Weight is applied only when included[c]=1.
- Accumulation:
  - xsum+=w·x; ysum+=w·y; cnt+=w.
  - All three accumulators saturate at all-ones.
- Frame boundary (pix_valid&&sof):
  - If IDLE: snapshot the accumulators into divider operand registers, enter DIV.
  - If busy: discard the snapshot, set overrun, keep the previous outputs.
  - In both cases, reload the accumulators with the current pixel's contribution (or 0) in the same cycle.
- Divider FSM: IDLE → LOAD → DIV → NEXT → … → DONE → IDLE.
  - LOAD: select operand for job j = 0..2·NUM_CH−1; order is ch0x, ch0y, ch1x, …
  - DIV: ACC_W iterations of restoring division, one quotient bit per cycle, MSB first.
  - NEXT: write the result, then advance j or go to DONE.
  - Per-job latency is ACC_W+2 cycles.
  - DONE: result_valid=1 for exactly one cycle; all outputs update atomically in that cycle from the staging registers.
- Result rules:
  - If cnt==0: outputs are X_DEF/Y_DEF and found[c]=0, and the divider iterations are skipped (job latency 2 cycles).
  - Otherwise: output = quotient[9:0]+offset, truncated mod 2^10, and found[c]=1.
- Reset values:
  - Accumulators, history, found, result_valid, busy, overrun: 0.
  - Centres: X_DEF/Y_DEF.
  - FSM: IDLE.
  - Reset mid-division aborts the job without a result_valid pulse.
- Config inputs are sampled live every pixel; changing them mid-frame is permitted and affects subsequent pixels only.

Test Plan:
- 1 ch, ch_sel=0, min=5, diff=3:
  - Stimulus: 10×1 red pixels (R=31, G=B=0) at x=100..109, y=50, then sof.
  - Expected sums: cnt = 1+2+4·8 = 35; xsum = 100·1+101·2+4·(102+…+109).
  - Required response: x_center = xsum/35 + 152; y_center = 50+144 = 194; found=1; result_valid exactly once.
- Empty frame, all pixels black, then sof -> x_center=512, y_center=384, found=0.
- Threshold edge:
  - R=ch_min is rejected; R=ch_min+1 with G=B=0 and diff=0 is accepted.
  - R=20, G=17, diff=3 is rejected (margin not >3).
- 2 ch (R, B): alternating red/blue columns -> independent centroids per channel, and the weights show no red/blue cross-influence in history.
- sof issued again 10 cycles after the first -> overrun=1; the later result_valid reflects the first frame only; the second snapshot is lost.
- Reset asserted mid-DIV -> busy=0 next cycle, no result_valid, outputs return to defaults, overrun cleared.
